dual_port_block_ram: RTL and testbench
======================================

Name: dual_port_block_ram

Overview:
Parametrised true-dual-port behavioural block RAM, the successor to the single-port behavioural block RAM used in test benches and behavioural builds. Two independent read/write ports share one clock. Adds byte-lane write enables, a selectable write mode, per-port read-valid tracking through the latch and register stages, and collision detection. Used wherever two agents need simultaneous access to a shared buffer, for example a CPU and a DMA engine or a producer and a consumer.

Parameters:
AddrWidth, 12, address bits; depth = 1<<AddrWidth words.
DataWidth, 32, word width; must be a multiple of ByteWidth.
ByteWidth, 8, bits per write-enable lane; NumLanes = DataWidth/ByteWidth.
WriteMode, 0, 0 = write-first, 1 = read-first, 2 = no-change; applies to both ports.

Ports:
clka  in  1  single clock for both ports
rsta  in  1  asynchronous active-high reset
ena  in  1  port A enable
wea  in  NumLanes  port A byte-lane write enables
addra  in  AddrWidth  port A address
dina  in  DataWidth  port A write data
douta  out  DataWidth  port A latch output (1-cycle latency)
vlda  out  1  douta holds data from a read issued last cycle
regcea  in  1  port A output-register enable
Regdouta  out  DataWidth  port A registered output (2-cycle latency)
Regvlda  out  1  Regdouta holds valid read data
enb, web, addrb, dinb, doutb, vldb, regceb, Regdoutb, Regvldb: port B, same widths and meaning
collision  out  1  registered pulse: same-address conflict last cycle
busy  out  1  memory-clear in progress (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, rsta=1): douta, doutb, Regdouta, Regdoutb = 0; vlda, vldb, Regvlda, Regvldb, collision = 0. Memory contents are not reset.
- Write: on posedge with enX=1, each lane i with weX[i]=1 writes dinX lane i into Mem[addrX]. Lanes with weX[i]=0 keep their value.
- Read, enX=1 and weX=0: doutX = Mem[addrX] at the next edge; vldX=1.
- Read with any lane written, enX=1 and weX!=0:
  - WriteMode 0: doutX = merged new word (written lanes from din, other lanes old). vldX=1.
  - WriteMode 1: doutX = old word. vldX=1.
  - WriteMode 2: doutX holds its value. vldX=0.
- enX=0: doutX holds its value; vldX=0.
- Register stage: on posedge with regceX=1, RegdoutX<=doutX and RegvldX<=vldX. With regceX=0 both hold.
- Collision (enA & enB & addra==addrb, evaluated each cycle):
  - Both write overlapping lanes: port A data wins on those lanes; non-overlapping lanes from each port are both written. collision=1 next cycle.
  - One port writes, the other reads: the reader returns the old word, regardless of WriteMode. collision=1 next cycle.
  - Both read: no collision; both ports return identical data.
- collision is a one-cycle pulse per conflicting cycle. Back-to-back conflicts hold it high.
- Reset asserted mid-access: outputs clear immediately; the write on a cycle where rsta=1 at the edge is suppressed.

Optional Feature:
- Macro: BRAM_MEMCLR_EN.
- Defined: a 2-state FSM, CLEAR and IDLE. The FSM enters CLEAR on reset. After rsta deasserts, it writes 0 to one address per cycle, 0 up to depth-1.
  - busy=1 throughout CLEAR. Port enables are ignored and vld outputs are forced 0.
  - On the cycle after address depth-1 is written, the FSM moves to IDLE and busy=0.
  - Reset asserted mid-clear restarts the clear from address 0.
- Undefined: no FSM; busy tied 0; memory powers up uninitialised (X in simulation); ports are usable on the first edge after reset.

Test Plan:
- Port A writes 0xDEADBEEF @0x010 with wea=4'hF, then port B reads @0x010 -> doutb=0xDEADBEEF, vldb=1 one cycle after the read edge; with regceb=1, Regdoutb=0xDEADBEEF one cycle later.
- Mem[0x020]=0x11223344; port A writes 0xAABBCCDD with wea=4'b0101 -> next read returns 0x11BB33DD.
- WriteMode 0/1/2 with Mem[5]=0x1, write 0x2 @5 with read -> douta = 0x2 / 0x1 / held previous value with vlda=0, respectively.
- Same cycle: A writes 0xAAAAAAAA @7, B writes 0xBBBBBBBB @7, both wea=webb=4'hF -> Mem[7]=0xAAAAAAAA; collision=1 for exactly one cycle. Then A writes @8 while B reads @8 (old 0x0) -> doutb=0x0, collision=1.
- Assert rsta mid-burst with Regdouta=0x1234 -> all data outputs, vld outputs and collision read 0 immediately; the write on that edge is absent from memory.
- With BRAM_MEMCLR_EN, AddrWidth=4 -> busy=1 for 16 cycles after reset release, then 0; every address reads 0; reset pulsed at clear address 9 restarts the clear, giving 16 more busy cycles.

Source files
------------

// File: rtl/dual_port_block_ram.sv
// True-dual-port behavioural block RAM with byte-lane writes, selectable write mode,
// valid tracking and collision flag. Define BRAM_MEMCLR_EN to clear memory after reset.
module dual_port_block_ram #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int WriteMode = 0,
  localparam int NumLanes = DataWidth / ByteWidth
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 ena,
  input  logic [NumLanes-1:0]  wea,
  input  logic [AddrWidth-1:0] addra,
  input  logic [DataWidth-1:0] dina,
  output logic [DataWidth-1:0] douta,
  output logic                 vlda,
  input  logic                 regcea,
  output logic [DataWidth-1:0] Regdouta,
  output logic                 Regvlda,
  input  logic                 enb,
  input  logic [NumLanes-1:0]  web,
  input  logic [AddrWidth-1:0] addrb,
  input  logic [DataWidth-1:0] dinb,
  output logic [DataWidth-1:0] doutb,
  output logic                 vldb,
  input  logic                 regceb,
  output logic [DataWidth-1:0] Regdoutb,
  output logic                 Regvldb,
  output logic                 collision,
  output logic                 busy
);

  localparam int Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];

  logic                 clr_act;
  logic                 en_a, en_b;
  logic [DataWidth-1:0] old_a, old_b, mrg_a, mrg_b;
  logic [DataWidth-1:0] douta_q, doutb_q, regdouta_q, regdoutb_q;
  logic                 vlda_q, vldb_q, regvlda_q, regvldb_q, collision_q;
  logic                 collision_d;

`ifdef BRAM_MEMCLR_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_e;
  state_e               state_q;
  logic [AddrWidth-1:0] clr_addr_q;
  logic                 busy_q;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else if (state_q == S_CLEAR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
      if (clr_addr_q == {AddrWidth{1'b1}}) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign clr_act = (state_q == S_CLEAR);
  assign busy    = busy_q;
`else
  assign clr_act = 1'b0;
  assign busy    = 1'b0;
`endif

  assign en_a = ena & ~clr_act;
  assign en_b = enb & ~clr_act;

  always_comb begin
    old_a = mem_q[addra];
    old_b = mem_q[addrb];
    mrg_a = old_a;
    mrg_b = old_b;
    for (int i = 0; i < NumLanes; i++) begin
      if (wea[i]) mrg_a[i*ByteWidth +: ByteWidth] = dina[i*ByteWidth +: ByteWidth];
      if (web[i]) mrg_b[i*ByteWidth +: ByteWidth] = dinb[i*ByteWidth +: ByteWidth];
    end
  end

  assign collision_d = en_a & en_b & (addra == addrb) & ((|wea) | (|web));

  // Reset branch is empty: contents are kept, only the write on a reset edge is dropped.
  // Port A lanes are written last so A wins on overlapping lanes.
  always_ff @(posedge clka or posedge rsta) begin
    if (!rsta) begin
`ifdef BRAM_MEMCLR_EN
      if (clr_act) mem_q[clr_addr_q] <= '0;
`endif
      for (int i = 0; i < NumLanes; i++) begin
        if (en_b && web[i]) mem_q[addrb][i*ByteWidth +: ByteWidth] <= dinb[i*ByteWidth +: ByteWidth];
      end
      for (int i = 0; i < NumLanes; i++) begin
        if (en_a && wea[i]) mem_q[addra][i*ByteWidth +: ByteWidth] <= dina[i*ByteWidth +: ByteWidth];
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      douta_q     <= '0;
      doutb_q     <= '0;
      vlda_q      <= 1'b0;
      vldb_q      <= 1'b0;
      regdouta_q  <= '0;
      regdoutb_q  <= '0;
      regvlda_q   <= 1'b0;
      regvldb_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;

      // A pure reader always sees the pre-write word, which also covers cross-port conflicts.
      if (!en_a) begin
        vlda_q <= 1'b0;
      end else if (wea == '0 || WriteMode == 1) begin
        douta_q <= old_a;
        vlda_q  <= 1'b1;
      end else if (WriteMode == 0) begin
        douta_q <= mrg_a;
        vlda_q  <= 1'b1;
      end else begin
        vlda_q  <= 1'b0;
      end

      if (!en_b) begin
        vldb_q <= 1'b0;
      end else if (web == '0 || WriteMode == 1) begin
        doutb_q <= old_b;
        vldb_q  <= 1'b1;
      end else if (WriteMode == 0) begin
        doutb_q <= mrg_b;
        vldb_q  <= 1'b1;
      end else begin
        vldb_q  <= 1'b0;
      end

      if (regcea) begin
        regdouta_q <= douta_q;
        regvlda_q  <= vlda_q;
      end
      if (regceb) begin
        regdoutb_q <= doutb_q;
        regvldb_q  <= vldb_q;
      end
    end
  end

  assign douta     = douta_q;
  assign doutb     = doutb_q;
  assign vlda      = vlda_q;
  assign vldb      = vldb_q;
  assign Regdouta  = regdouta_q;
  assign Regdoutb  = regdoutb_q;
  assign Regvlda   = regvlda_q;
  assign Regvldb   = regvldb_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Directed bench for dual_port_block_ram: three instances share stimulus, one per write mode.
// With BRAM_MEMCLR_EN defined, an extra 16-word instance exercises the clear sequence.
module tb_dual_port_block_ram;

  logic        clka = 1'b0;
  logic        rsta;
  logic        ena, enb, regcea, regceb;
  logic [3:0]  wea, web;
  logic [11:0] addra, addrb;
  logic [31:0] dina, dinb;

  logic [31:0] douta [3];
  logic [31:0] doutb [3];
  logic [31:0] Regdouta [3];
  logic [31:0] Regdoutb [3];
  logic        vlda [3];
  logic        vldb [3];
  logic        Regvlda [3];
  logic        Regvldb [3];
  logic        collision [3];
  logic        busy [3];

  int errors = 0;
  int checks = 0;

  always #5 clka = ~clka;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dual_port_block_ram #(.WriteMode(g)) u_dut (
      .clka(clka), .rsta(rsta),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[g]), .vlda(vlda[g]),
      .regcea(regcea), .Regdouta(Regdouta[g]), .Regvlda(Regvlda[g]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[g]), .vldb(vldb[g]),
      .regceb(regceb), .Regdoutb(Regdoutb[g]), .Regvldb(Regvldb[g]),
      .collision(collision[g]), .busy(busy[g])
    );
  end

`ifdef BRAM_MEMCLR_EN
  logic [31:0] douta_c, doutb_c, Regdouta_c, Regdoutb_c;
  logic        vlda_c, vldb_c, Regvlda_c, Regvldb_c, collision_c, busy_c;

  dual_port_block_ram #(.AddrWidth(4)) u_dut_c (
    .clka(clka), .rsta(rsta),
    .ena(ena), .wea(wea), .addra(addra[3:0]), .dina(dina), .douta(douta_c), .vlda(vlda_c),
    .regcea(regcea), .Regdouta(Regdouta_c), .Regvlda(Regvlda_c),
    .enb(enb), .web(web), .addrb(addrb[3:0]), .dinb(dinb), .doutb(doutb_c), .vldb(vldb_c),
    .regceb(regceb), .Regdoutb(Regdoutb_c), .Regvldb(Regvldb_c),
    .collision(collision_c), .busy(busy_c)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic drv_a(input logic e, input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
    ena = e; wea = w; addra = a; dina = d;
  endtask

  task automatic drv_b(input logic e, input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
    enb = e; web = w; addrb = a; dinb = d;
  endtask

  // Main instances clear 4096 words when the clear feature is built in.
  task automatic wait_clear();
`ifdef BRAM_MEMCLR_EN
    int n = 0;
    while (busy[0] && n < 5000) begin
      n++;
      tick();
    end
    chk("clear_done", busy[0], 1'b0);
`endif
  endtask

`ifdef BRAM_MEMCLR_EN
  task automatic count_busy(input string tag);
    int n = 0;
    while (busy_c && n < 40) begin
      n++;
      @(negedge clka);
    end
    chk(tag, n, 16);
  endtask
`endif

  initial begin
    rsta = 1'b1; regcea = 1'b0; regceb = 1'b0;
    drv_a(0, 4'h0, 12'h0, 32'h0);
    drv_b(0, 4'h0, 12'h0, 32'h0);
    repeat (2) @(negedge clka);

    for (int m = 0; m < 3; m++) begin
      chk("rst_douta", douta[m], 32'h0);
      chk("rst_vlda", vlda[m], 1'b0);
      chk("rst_regvldb", Regvldb[m], 1'b0);
    end
    chk("rst_regdouta", Regdouta[0], 32'h0);
    chk("rst_doutb", doutb[0], 32'h0);
    chk("rst_collision", collision[0], 1'b0);
`ifdef BRAM_MEMCLR_EN
    chk("rst_busy", busy[0], 1'b1);
`else
    chk("rst_busy", busy[0], 1'b0);
`endif
    rsta = 1'b0;
    wait_clear();

    // Full-word write on A, read back on B through the register stage
    drv_a(1, 4'hF, 12'h010, 32'hDEADBEEF);
    tick();
    chk("wf_wr_douta", douta[0], 32'hDEADBEEF);
    chk("wf_wr_vlda", vlda[0], 1'b1);
    chk("nc_wr_vlda", vlda[2], 1'b0);
    drv_a(0, 4'h0, 12'h0, 32'h0);
    drv_b(1, 4'h0, 12'h010, 32'h0);
    regceb = 1'b1;
    tick();
    chk("rd_doutb", doutb[0], 32'hDEADBEEF);
    chk("rd_vldb", vldb[0], 1'b1);
    chk("idle_vlda", vlda[0], 1'b0);
    chk("reg_lat_regvldb", Regvldb[0], 1'b0);
    drv_b(0, 4'h0, 12'h0, 32'h0);
    tick();
    chk("reg_regdoutb", Regdoutb[0], 32'hDEADBEEF);
    chk("reg_regvldb", Regvldb[0], 1'b1);
    chk("idle_vldb", vldb[0], 1'b0);
    chk("idle_doutb_hold", doutb[0], 32'hDEADBEEF);
    regceb = 1'b0;
    tick();
    chk("regce0_hold", Regvldb[0], 1'b1);

    // Byte lanes and write modes
    drv_a(1, 4'hF, 12'h020, 32'h11223344);
    tick();
    drv_a(1, 4'hF, 12'h005, 32'h00000001);
    tick();
    drv_a(1, 4'h0, 12'h020, 32'h0);
    tick();
    chk("nc_rd_douta", douta[2], 32'h11223344);
    drv_a(1, 4'b0101, 12'h020, 32'hAABBCCDD);
    tick();
    chk("wf_lane_douta", douta[0], 32'h11BB33DD);
    chk("rf_lane_douta", douta[1], 32'h11223344);
    chk("rf_lane_vlda", vlda[1], 1'b1);
    chk("nc_lane_hold", douta[2], 32'h11223344);
    chk("nc_lane_vlda", vlda[2], 1'b0);
    drv_a(1, 4'h0, 12'h020, 32'h0);
    tick();
    chk("lane_merge_wf", douta[0], 32'h11BB33DD);
    chk("lane_merge_nc", douta[2], 32'h11BB33DD);
    drv_a(1, 4'hF, 12'h005, 32'h00000002);
    tick();
    chk("wm0_douta", douta[0], 32'h00000002);
    chk("wm1_douta", douta[1], 32'h00000001);
    chk("wm2_douta", douta[2], 32'h11BB33DD);
    chk("wm2_vlda", vlda[2], 1'b0);

    // Write/write collision: A wins
    drv_a(1, 4'hF, 12'h007, 32'hAAAAAAAA);
    drv_b(1, 4'hF, 12'h007, 32'hBBBBBBBB);
    tick();
    chk("ww_collision", collision[0], 1'b1);
    drv_a(1, 4'hF, 12'h008, 32'h0);
    drv_b(0, 4'h0, 12'h0, 32'h0);
    tick();
    chk("ww_pulse_end", collision[0], 1'b0);
    drv_a(1, 4'hF, 12'h009, 32'h0);
    drv_b(1, 4'h0, 12'h007, 32'h0);
    tick();
    chk("ww_a_wins", doutb[0], 32'hAAAAAAAA);
    chk("diff_addr_nocoll", collision[0], 1'b0);

    // Write/read collision: reader gets the old word in every mode
    drv_a(1, 4'hF, 12'h008, 32'h12345678);
    drv_b(1, 4'h0, 12'h008, 32'h0);
    tick();
    chk("wr_coll_doutb_wf", doutb[0], 32'h0);
    chk("wr_coll_doutb_nc", doutb[2], 32'h0);
    chk("wr_coll_vldb_nc", vldb[2], 1'b1);
    chk("wr_coll_flag", collision[0], 1'b1);
    chk("wr_coll_douta_wf", douta[0], 32'h12345678);
    drv_a(1, 4'h0, 12'h008, 32'h0);
    tick();
    chk("rr_nocoll", collision[0], 1'b0);
    chk("rr_same_data", doutb[0], 32'h12345678);

    // Partial overlapping writes, then back-to-back conflict
    drv_a(1, 4'b0011, 12'h009, 32'h0000A1A0);
    drv_b(1, 4'b0110, 12'h009, 32'h00B2B100);
    tick();
    chk("pw_collision", collision[0], 1'b1);
    drv_a(1, 4'b0000, 12'h009, 32'h0);
    drv_b(1, 4'b1000, 12'h009, 32'hFF000000);
    tick();
    chk("b2b_collision", collision[0], 1'b1);
    chk("pw_merge_old", douta[0], 32'h00B2A1A0);
    drv_b(1, 4'h0, 12'h009, 32'h0);
    tick();
    chk("b2b_end", collision[0], 1'b0);
    chk("pw_final_a", douta[0], 32'hFFB2A1A0);
    chk("pw_final_b", doutb[0], 32'hFFB2A1A0);

    // Reset in the middle of traffic
    drv_b(0, 4'h0, 12'h0, 32'h0);
    drv_a(1, 4'hF, 12'h030, 32'h00001234);
    regcea = 1'b1;
    tick();
    drv_a(1, 4'h0, 12'h030, 32'h0);
    tick();
    chk("pre_rst_regdouta", Regdouta[0], 32'h00001234);
    chk("pre_rst_regvlda", Regvlda[0], 1'b1);
    drv_a(1, 4'hF, 12'h030, 32'h00005555);
    drv_b(1, 4'h0, 12'h030, 32'h0);
    rsta = 1'b1;
    #1;
    chk("mid_rst_regdouta", Regdouta[0], 32'h0);
    chk("mid_rst_regvlda", Regvlda[0], 1'b0);
    chk("mid_rst_douta", douta[0], 32'h0);
    chk("mid_rst_vlda", vlda[0], 1'b0);
    chk("mid_rst_doutb", doutb[0], 32'h0);
    tick();
    rsta = 1'b0;
    regcea = 1'b0;
    drv_a(0, 4'h0, 12'h0, 32'h0);
    drv_b(0, 4'h0, 12'h0, 32'h0);
    wait_clear();
    drv_a(1, 4'h0, 12'h030, 32'h0);
    tick();
`ifdef BRAM_MEMCLR_EN
    chk("rst_write_dropped", douta[0], 32'h0);
`else
    chk("rst_write_dropped", douta[0], 32'h00001234);
`endif
    drv_a(0, 4'h0, 12'h0, 32'h0);

`ifdef BRAM_MEMCLR_EN
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    count_busy("clr_busy_cycles");
    for (int i = 0; i < 16; i++) begin
      drv_a(1, 4'hF, 12'(i), 32'hFFFFFFFF);
      tick();
    end
    drv_a(0, 4'h0, 12'h0, 32'h0);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    repeat (9) tick();
    chk("clr_mid_busy", busy_c, 1'b1);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    count_busy("clr_restart_cycles");
    for (int i = 0; i < 16; i++) begin
      drv_a(1, 4'h0, 12'(i), 32'h0);
      tick();
      chk("clr_word_zero", douta_c, 32'h0);
      chk("clr_word_vld", vlda_c, 1'b1);
    end
    drv_a(0, 4'h0, 12'h0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
